pad_in_cond: RTL

- Consumes the receive-side outputs of the pad ring, i.e. the C outputs of the RSTN and CLK_RD input pads.
- Synchronizes both into the core clock domain and glitch-filters them.
- Sequences release of the core functional reset.
- Converts the filtered external read clock into single-cycle rise/fall strobes for the capture readout logic.

---
 rtl/pad_in_cond_pkg.sv | 16 +
 rtl/pad_in_cond_if.sv | 35 +++
 rtl/pad_sync_filt.sv | 54 +++++
 rtl/pad_in_cond.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pad_in_cond_pkg.sv
// Shared constants and types for the pad input conditioner.
// The optional glitch counter is enabled by defining PAD_IN_COND_GLITCH_CNT_EN.
package pad_in_cond_pkg;

  localparam int unsigned FILT_CNT_W   = 4;
  localparam int unsigned GLITCH_CNT_W = 8;
  localparam int unsigned RST_STATE_W  = 2;
  localparam int unsigned HOLD_CNT_W   = 8;

  typedef enum logic [RST_STATE_W-1:0] {
    RST_ASSERT  = 2'd0,
    RST_HOLD_ST = 2'd1,
    RST_RUN     = 2'd2
  } rst_state_e;

endpackage

// File: rtl/pad_in_cond_if.sv
// Pad receive inputs and conditioned outputs of pad_in_cond.
// glitch_cnt exists only when PAD_IN_COND_GLITCH_CNT_EN is defined.
interface pad_in_cond_if;
  import pad_in_cond_pkg::*;

  logic                    pad_rstn_c;
  logic                    pad_clk_rd_c;
  logic                    core_rst_n;
  logic                    clk_rd_lvl;
  logic                    clk_rd_rise;
  logic                    clk_rd_fall;
  logic [RST_STATE_W-1:0]  rst_state;
`ifdef PAD_IN_COND_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_cnt;

  modport master (
    output pad_rstn_c, pad_clk_rd_c,
    input  core_rst_n, clk_rd_lvl, clk_rd_rise, clk_rd_fall, rst_state, glitch_cnt
  );
  modport slave (
    input  pad_rstn_c, pad_clk_rd_c,
    output core_rst_n, clk_rd_lvl, clk_rd_rise, clk_rd_fall, rst_state, glitch_cnt
  );
`else
  modport master (
    output pad_rstn_c, pad_clk_rd_c,
    input  core_rst_n, clk_rd_lvl, clk_rd_rise, clk_rd_fall, rst_state
  );
  modport slave (
    input  pad_rstn_c, pad_clk_rd_c,
    output core_rst_n, clk_rd_lvl, clk_rd_rise, clk_rd_fall, rst_state
  );
`endif

endinterface

// File: rtl/pad_sync_filt.sv
// Synchronizer plus stable-count glitch filter for one asynchronous pad input.
// glitch_c (rejected-glitch pulse) exists only with PAD_IN_COND_GLITCH_CNT_EN.
module pad_sync_filt
  import pad_in_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_c,
`ifdef PAD_IN_COND_GLITCH_CNT_EN
  output logic glitch_c,
`endif
  output logic lvl
);

  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_CNT_W-1:0]  cnt_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Plain shift synchronizer, no logic between stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_c};
    end
  end

  // Level flips only after FILT_LEN consecutive cycles of disagreement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lvl   <= 1'b0;
    end else if (sync_out == lvl) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      lvl   <= ~lvl;
    end else begin
      cnt_q <= cnt_q + FILT_CNT_W'(1);
    end
  end

`ifdef PAD_IN_COND_GLITCH_CNT_EN
  assign glitch_c = (sync_out == lvl) && (cnt_q != '0);
`endif

endmodule

// File: rtl/pad_in_cond.sv
// Pad receive conditioner: RSTN/CLK_RD sync + filter, core reset sequencing, CLK_RD strobes.
// Define PAD_IN_COND_GLITCH_CNT_EN to add the saturating rejected-glitch counter.
module pad_in_cond
  import pad_in_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned RST_HOLD    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  pad_in_cond_if.slave pads
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RST_HOLD - 1);

  logic                  rstn_flt;
  logic                  clk_flt;
  rst_state_e            state_q;
  rst_state_e            state_d;
  logic [HOLD_CNT_W-1:0] hold_q;
  logic [HOLD_CNT_W-1:0] hold_d;
  logic                  core_rst_n_q;
  logic                  lvl_d_q;
  logic                  rise_q;
  logic                  fall_q;

`ifdef PAD_IN_COND_GLITCH_CNT_EN
  localparam int unsigned GSUM_W = GLITCH_CNT_W + 1;

  logic                    rst_glitch_c;
  logic                    clk_glitch_c;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q;
  logic [GSUM_W-1:0]       glitch_sum_c;
`endif

  pad_sync_filt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_rstn_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .pad_c    (pads.pad_rstn_c),
`ifdef PAD_IN_COND_GLITCH_CNT_EN
    .glitch_c (rst_glitch_c),
`endif
    .lvl      (rstn_flt)
  );

  pad_sync_filt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_clk_rd_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .pad_c    (pads.pad_clk_rd_c),
`ifdef PAD_IN_COND_GLITCH_CNT_EN
    .glitch_c (clk_glitch_c),
`endif
    .lvl      (clk_flt)
  );

  // Reset sequencer next state: ASSERT -> HOLD (RST_HOLD cycles) -> RUN
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      RST_ASSERT: begin
        if (rstn_flt) begin
          state_d = RST_HOLD_ST;
          hold_d  = '0;
        end
      end
      RST_HOLD_ST: begin
        if (!rstn_flt) begin
          state_d = RST_ASSERT;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RST_RUN;
        end else begin
          hold_d = hold_q + HOLD_CNT_W'(1);
        end
      end
      RST_RUN: begin
        if (!rstn_flt) begin
          state_d = RST_ASSERT;
        end
      end
      default: state_d = RST_ASSERT;
    endcase
  end

  // Strobes are gated by the next state so they are only ever visible alongside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST_ASSERT;
      hold_q       <= '0;
      core_rst_n_q <= 1'b0;
      lvl_d_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      core_rst_n_q <= (state_d == RST_RUN);
      lvl_d_q      <= clk_flt;
      rise_q       <= (state_d == RST_RUN) &&  clk_flt && !lvl_d_q;
      fall_q       <= (state_d == RST_RUN) && !clk_flt &&  lvl_d_q;
    end
  end

`ifdef PAD_IN_COND_GLITCH_CNT_EN
  assign glitch_sum_c = {1'b0, glitch_cnt_q} + GSUM_W'(rst_glitch_c) + GSUM_W'(clk_glitch_c);

  // Saturating count of rejected glitches on either input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt_q <= '0;
    end else if (glitch_sum_c[GSUM_W-1]) begin
      glitch_cnt_q <= '1;
    end else begin
      glitch_cnt_q <= glitch_sum_c[GLITCH_CNT_W-1:0];
    end
  end

  assign pads.glitch_cnt = glitch_cnt_q;
`endif

  assign pads.core_rst_n  = core_rst_n_q;
  assign pads.clk_rd_lvl  = clk_flt;
  assign pads.clk_rd_rise = rise_q;
  assign pads.clk_rd_fall = fall_q;
  assign pads.rst_state   = state_q;

endmodule
